rr_grant_arbiter4: RTL and testbench
====================================

Name: rr_grant_arbiter4

Overview:
- Four-requester round-robin arbiter. Drives the one-hot request bus and enable of the 4-to-2 priority encoder stage, which turns the grant into a 2-bit index.
- Holds each grant until the requester releases it or a hold timeout expires.
- Guarantees the downstream encoder only ever sees a clean one-hot word, or all-zero with the enable low.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant stays asserted before a forced release. Legal range 1 to 2**HOLD_W-1.
- HOLD_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the resource. Level-sensitive.
- done  input  1  single-cycle release strobe from the current owner.
- grant  output  4  registered one-hot grant; all-zero when idle. Feeds the encoder D input.
- grant_valid  output  1  registered; high exactly when grant is non-zero. Feeds the encoder E input.
- timeout  output  1  registered one-cycle pulse, high when a grant was force-released by the hold limit.

Behaviour:
- Reset (async, rst=1):
  - grant=4'b0000, grant_valid=0, timeout=0.
  - State IDLE, ptr=2'd0, hold_cnt=0.
  - Reset asserted mid-grant clears grant immediately, without waiting for a clock edge.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise search req[ptr], req[ptr+1], req[ptr+2], req[ptr+3], all indices mod 4. The first set bit i wins.
  - At the next edge: grant=one-hot(i), grant_valid=1, idx=i, hold_cnt=0, ptr=(i+1) mod 4, state GRANT.
  - Latency from a req edge sampled in IDLE to grant visible: 1 cycle.
- State GRANT (each edge, conditions evaluated in this priority):
  1. done=1, or req[idx]=0: release. Next edge grant=0, grant_valid=0, timeout=0, state IDLE.
  2. hold_cnt==MAX_HOLD-1: forced release. Next edge grant=0, grant_valid=0, timeout=1 for exactly one cycle, state IDLE.
  3. Otherwise hold_cnt increments and grant is unchanged.
- If done and the timeout condition coincide, done wins and timeout stays 0.
- A grant therefore lasts at most MAX_HOLD cycles.
- After every release there is exactly one IDLE cycle (dead cycle) before the next grant. No back-to-back grants.
- Fairness:
  - ptr advances only on a grant.
  - A requester that is continuously asserted waits at most 3 grants.
- done while in IDLE is ignored.
- Changes on req bits other than idx while in GRANT are ignored.
- Invariants, checked every cycle:
  - grant is 0 or one-hot.
  - grant_valid == |grant.
  - timeout never coincides with grant_valid=1.
- hold_cnt never wraps. It resets to 0 on each new grant.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=1'b0, ST_GRANT=1'b1;
  - NUM_REQ=4;
  - the index-to-one-hot conversion function, reused by other arbitration blocks.
- One natural sub-module: rr_pick4, a purely combinational rotate-and-find-first.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - The top level holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset then req=4'b0101: grant=4'b0001 one cycle later and ptr=1. Pulse done: grant=0 for 1 cycle, then grant=4'b0100.
- req=4'b1111 held, with done pulsed one cycle after each grant: grant sequence is 0001, 0010, 0100, 1000, 0001, with a zero cycle between each.
- MAX_HOLD=4, req=4'b0010 held, no done: grant=0010 for exactly 4 cycles, then grant=0 and timeout=1 for one cycle. Regrant of 0010 follows after the dead cycle.
- done and the timeout condition in the same cycle (MAX_HOLD=4, done on the 4th grant cycle): release occurs and timeout stays 0.
- Owner drops req mid-grant (req 4'b1000 to 4'b0000): grant=0 on the next edge, timeout=0.
- rst pulsed asynchronously, between edges, while grant=0100: grant and grant_valid go 0 immediately. After release, req=4'b0100 yields grant=0100 with search restarting from ptr=0.

Source files
------------

// File: rtl/rr_grant_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state codes, debug view
// and the index-to-one-hot helper used by other arbitration blocks.
package rr_grant_arbiter4_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef struct packed {
        logic [0:0] state;
        logic [1:0] ptr;
        logic [1:0] idx;
    } arb_dbg_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter4_pick.sv
// Combinational rotate-and-find-first: first set req bit at or after ptr, mod 4.
module rr_pick4
    import rr_grant_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         idx
);

    logic [1:0] pos;

    // Walk from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + 2'(k);
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter4.sv
// Four-requester round-robin arbiter with hold timeout; drives the one-hot word
// and enable of the downstream 4-to-2 priority encoder.
module rr_grant_arbiter4
    import rr_grant_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic               timeout,
    output arb_dbg_t           dbg
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]         state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [1:0]         pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    idx_d   = pick_idx;
                    ptr_d   = pick_idx + 2'd1;
                    hold_d  = '0;
                    grant_d = idx_to_onehot(pick_idx);
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Owner release beats the hold limit, so a coinciding done never flags timeout.
                if (done || !req[idx_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;
    assign dbg         = '{state: state_q, ptr: ptr_q, idx: idx_q};

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Bench for rr_grant_arbiter4: two instances (MAX_HOLD 15 and 4) on shared inputs,
// compared each cycle against an owner/held-cycles reference model.
module tb_rr_grant_arbiter4;
    import rr_grant_arbiter4_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;

    logic [3:0] grant0, grant1;
    logic       valid0, valid1, to0, to1;
    arb_dbg_t   dbg0, dbg1;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: owner index (-1 idle), visible grant cycles, search start
    int m_owner[2];
    int m_held[2];
    int m_start[2];
    bit m_to[2];
    int m_max[2];

    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    rr_grant_arbiter4 u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant0), .grant_valid(valid0), .timeout(to0), .dbg(dbg0)
    );

    rr_grant_arbiter4 #(.MAX_HOLD(4), .HOLD_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant1), .grant_valid(valid1), .timeout(to1), .dbg(dbg1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_start[d] = 0;
            m_to[d]    = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic dn);
        for (int d = 0; d < 2; d++) begin
            m_to[d] = 1'b0;
            if (m_owner[d] < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner[d] < 0 && r[(m_start[d] + k) % 4]) begin
                        m_owner[d] = (m_start[d] + k) % 4;
                        m_held[d]  = 1;
                        m_start[d] = (m_owner[d] + 1) % 4;
                    end
                end
            end else if (dn || !r[m_owner[d]]) begin
                m_owner[d] = -1;
            end else if (m_held[d] == m_max[d]) begin
                m_owner[d] = -1;
                m_to[d]    = 1'b1;
            end else begin
                m_held[d]++;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant(input int d);
        logic [3:0] g;
        g = '0;
        if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
        return g;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "/grant0"}, 32'(grant0), 32'(exp_grant(0)));
        check({tag, "/valid0"}, 32'(valid0), 32'(m_owner[0] >= 0));
        check({tag, "/to0"},    32'(to0),    32'(m_to[0]));
        check({tag, "/ptr0"},   32'(dbg0.ptr), 32'(m_start[0]));
        check({tag, "/grant1"}, 32'(grant1), 32'(exp_grant(1)));
        check({tag, "/valid1"}, 32'(valid1), 32'(m_owner[1] >= 0));
        check({tag, "/to1"},    32'(to1),    32'(m_to[1]));
        check({tag, "/ptr1"},   32'(dbg1.ptr), 32'(m_start[1]));
        check({tag, "/onehot"}, 32'($onehot0(grant0) && $onehot0(grant1)), 32'd1);
        check({tag, "/to_excl"}, 32'((to0 && valid0) || (to1 && valid1)), 32'd0);
    endtask

    // drive inputs at a falling edge; next rising edge samples them
    task automatic tick(input string tag, input logic [3:0] r, input logic dn);
        req  = r;
        done = dn;
        model_step(r, dn);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        m_max[0] = 15;
        m_max[1] = 4;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset/grant", 32'(grant0), 32'h0);
        check("reset/state", 32'(dbg0.state), 32'(ST_IDLE));

        // basic grant, release, and pointer advance
        tick("t1a", 4'b0101, 1'b0);
        check("t1/first_grant", 32'(grant0), 32'h1);
        check("t1/ptr_after", 32'(dbg0.ptr), 32'd1);
        tick("t1b", 4'b0101, 1'b1);
        check("t1/dead", 32'(grant0), 32'h0);
        tick("t1c", 4'b0101, 1'b0);
        check("t1/second_grant", 32'(grant0), 32'h4);
        tick("t1d", 4'b0000, 1'b0);

        // full rotation with done one cycle after each grant
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick("t2", 4'b1111, m_owner[0] >= 0);
            if (grant0 != 4'b0000) got_q.push_back(grant0);
        end
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("t2/count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("t2/seq", 32'(i < got_q.size() ? got_q[i] : 4'hx), 32'(exp_q[i]));

        // hold limit on the MAX_HOLD=4 instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick("t3", 4'b0010, 1'b0);
            check("t3/held", 32'(grant1), 32'h2);
        end
        tick("t3e", 4'b0010, 1'b0);
        check("t3/to_pulse", 32'({grant1, to1}), 32'h1);
        tick("t3r", 4'b0010, 1'b0);
        check("t3/regrant", 32'({grant1, to1}), 32'h4);

        // done coinciding with the limit cycle
        do_reset();
        for (int i = 0; i < 4; i++) tick("t4", 4'b0010, 1'b0);
        tick("t4d", 4'b0010, 1'b1);
        check("t4/done_wins", 32'({grant1, to1}), 32'h0);

        // owner drops request
        do_reset();
        tick("t5a", 4'b1000, 1'b0);
        check("t5/grant", 32'(grant0), 32'h8);
        tick("t5b", 4'b0000, 1'b0);
        check("t5/drop", 32'({grant0, to0}), 32'h0);

        // asynchronous reset mid-grant
        do_reset();
        tick("t6a", 4'b0101, 1'b0);
        tick("t6b", 4'b0101, 1'b1);
        tick("t6c", 4'b0100, 1'b0);
        check("t6/held", 32'(grant0), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("t6/async_grant", 32'({grant0, grant1}), 32'h0);
        check("t6/async_valid", 32'({valid0, valid1}), 32'h0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        tick("t6d", 4'b0100, 1'b0);
        check("t6/after_reset", 32'(grant0), 32'h4);
        check("t6/ptr_restart", 32'(dbg0.ptr), 32'd3);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            tick("rand", r, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
